// File: rtl/timer_sequencer_if.sv
// Avalon-MM write-only master bus to the interval timer slave, plus its interrupt line.
interface timer_sequencer_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic        timer_irq;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  timer_irq
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output timer_irq
  );
endinterface

// File: rtl/timer_sequencer.sv
// Programs an interval timer over Avalon-MM and turns each acknowledged timeout into a tick.
// Optional tick counter is built when TIMER_SEQ_TICK_COUNT_EN is defined.
module timer_sequencer #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'h02FAF07F
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_enable,
  input  logic                     cfg_load,
  input  logic [31:0]              cfg_period,
  timer_sequencer_if.master        avm,
  output logic                     tick,
  output logic                     busy,
  output logic [31:0]              tick_count
);

  typedef enum logic [2:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    RUN,
    ACK,
    STOP
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_period;
  logic [31:0] w_next_period;
  logic        r_pending;
  logic        w_next_pending;

  logic        r_cs;
  logic        r_wn;
  logic [2:0]  r_addr;
  logic [15:0] r_wdata;
  logic        r_tick;
  logic        r_busy;

  logic        w_cs;
  logic        w_wn;
  logic [2:0]  w_addr;
  logic [15:0] w_wdata;
  logic        w_tick;
  logic        w_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_period  <= DEFAULT_PERIOD;
      r_pending <= 1'b0;
      r_cs      <= 1'b0;
      r_wn      <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_period  <= w_next_period;
      r_pending <= w_next_pending;
      r_cs      <= w_cs;
      r_wn      <= w_wn;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_tick    <= w_tick;
      r_busy    <= w_busy;
    end
  end

  // Bus outputs are decoded from the next state so the registered strobe lines up
  // with the cycle the FSM actually spends in each write state.
  always_comb begin
    w_next_state   = r_state;
    w_next_period  = r_period;
    w_next_pending = r_pending;
    w_cs           = 1'b0;
    w_wn           = 1'b1;
    w_addr         = '0;
    w_wdata        = '0;
    w_tick         = 1'b0;
    w_busy         = 1'b0;

    if (cfg_load) begin
      w_next_period  = (cfg_period < 32'd2) ? 32'd2 : cfg_period;
      w_next_pending = 1'b1;
    end

    case (r_state)
      IDLE:    if (cfg_enable) w_next_state = WR_PL;
      WR_PL:   w_next_state = WR_PH;
      WR_PH:   w_next_state = WR_CTRL;
      WR_CTRL: w_next_state = RUN;
      RUN: begin
        if (avm.timer_irq)   w_next_state = ACK;
        else if (!cfg_enable) w_next_state = STOP;
        else if (r_pending)   w_next_state = STOP;
      end
      ACK:     w_next_state = RUN;
      STOP:    w_next_state = cfg_enable ? WR_PL : IDLE;
      default: w_next_state = IDLE;
    endcase

    if (w_next_state == WR_PL) w_next_pending = 1'b0;

    case (w_next_state)
      WR_PL: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = 3'd2;
        w_wdata = w_next_period[15:0];
        w_busy  = 1'b1;
      end
      WR_PH: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = 3'd3;
        w_wdata = w_next_period[31:16];
        w_busy  = 1'b1;
      end
      WR_CTRL: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = 3'd1;
        w_wdata = 16'h0007;
        w_busy  = 1'b1;
      end
      ACK: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = 3'd0;
        w_wdata = 16'h0000;
        w_tick  = 1'b1;
        w_busy  = 1'b1;
      end
      STOP: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = 3'd1;
        w_wdata = 16'h0008;
        w_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  assign avm.avm_address    = r_addr;
  assign avm.avm_chipselect = r_cs;
  assign avm.avm_write_n    = r_wn;
  assign avm.avm_writedata  = r_wdata;
  assign tick               = r_tick;
  assign busy               = r_busy;

`ifdef TIMER_SEQ_TICK_COUNT_EN
  logic [31:0] r_tick_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_tick_count <= '0;
    else if (r_tick) r_tick_count <= r_tick_count + 32'd1;
  end

  assign tick_count = r_tick_count;
`else
  assign tick_count = '0;
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: records every bus write and checks it against hand-computed vectors.
module tb_timer_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cfg_enable;
  logic        cfg_load;
  logic [31:0] cfg_period;
  logic        tick;
  logic        busy;
  logic [31:0] tick_count;

  timer_sequencer_if bus ();

  timer_sequencer #(.DEFAULT_PERIOD(32'h02FAF07F)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_enable (cfg_enable),
    .cfg_load   (cfg_load),
    .cfg_period (cfg_period),
    .avm        (bus),
    .tick       (tick),
    .busy       (busy),
    .tick_count (tick_count)
  );

`ifdef TIMER_SEQ_TICK_COUNT_EN
  localparam int unsigned TC_INC = 1;
`else
  localparam int unsigned TC_INC = 0;
`endif

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
    int unsigned cyc;
    logic        bsy;
  } wr_t;

  wr_t         wq[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned n_ticks = 0;
  int unsigned n_viol  = 0;
  int unsigned last_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: records writes and flags strobe/idle-value protocol violations.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.avm_chipselect && !bus.avm_write_n)
        wq.push_back('{a: bus.avm_address, d: bus.avm_writedata, cyc: cyc, bsy: busy});
      if (bus.avm_chipselect == bus.avm_write_n) n_viol++;
      if (!bus.avm_chipselect && (bus.avm_address != 3'd0 || bus.avm_writedata != 16'h0)) n_viol++;
      if (tick) begin
        n_ticks++;
        if (!(bus.avm_chipselect && bus.avm_address == 3'd0)) n_viol++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
    wr_t         w;
    logic [31:0] got;
    logic [31:0] exp;
    exp = {13'b0, a, d};
    if (wq.size() == 0) begin
      got = '1;
      check(tag, got, exp);
    end else begin
      w        = wq.pop_front();
      got      = {13'b0, w.a, w.d};
      last_cyc = w.cyc;
      check(tag, got, exp);
      check({tag, "_busy"}, {31'b0, w.bsy}, 32'd1);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] p);
    cfg_period = p;
    cfg_load   = 1'b1;
    cycles(1);
    cfg_load   = 1'b0;
  endtask

  // Waits (bounded) for a write to the given address; returns 1 when seen.
  task automatic wait_wr(input logic [2:0] a, output logic found);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == a) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        found;
    int unsigned c0;
    int unsigned t0;

    reset_n       = 1'b0;
    cfg_enable    = 1'b0;
    cfg_load      = 1'b0;
    cfg_period    = '0;
    bus.timer_irq = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs",    {31'b0, bus.avm_chipselect}, 32'd0);
    check("rst_wn",    {31'b0, bus.avm_write_n},    32'd1);
    check("rst_addr",  {29'b0, bus.avm_address},    32'd0);
    check("rst_wdata", {16'b0, bus.avm_writedata},  32'd0);
    check("rst_busy",  {31'b0, busy},               32'd0);
    check("rst_tick",  {31'b0, tick},               32'd0);
    check("rst_tc",    tick_count,                  32'd0);

    // Idle with irq asserted: nothing should happen
    @(posedge clk); #1;
    reset_n       = 1'b1;
    bus.timer_irq = 1'b1;
    cycles(4);
    bus.timer_irq = 1'b0;
    check("idle_nowr",  wq.size(), 32'd0);
    check("idle_notick", n_ticks,  32'd0);

    // Initial programming with DEFAULT_PERIOD
    cfg_enable = 1'b1;
    cycles(6);
    exp_wr("init_pl", 3'd2, 16'hF07F); c0 = last_cyc;
    exp_wr("init_ph", 3'd3, 16'h02FA); check("init_ph_cyc", last_cyc - c0, 32'd1);
    exp_wr("init_ct", 3'd1, 16'h0007); check("init_ct_cyc", last_cyc - c0, 32'd2);
    @(negedge clk);
    check("run_busy", {31'b0, busy}, 32'd0);

    // Timeout acknowledge
    t0 = n_ticks;
    bus.timer_irq = 1'b1;
    wait_wr(3'd0, found);
    bus.timer_irq = 1'b0;
    check("ack_seen", {31'b0, found}, 32'd1);
    cycles(5);
    exp_wr("ack_wr", 3'd0, 16'h0000);
    check("ack_ticks", n_ticks - t0, 32'd1);
    check("ack_tc",    tick_count,   TC_INC);
    check("ack_nowr",  wq.size(),    32'd0);

    // Reload in RUN
    load(32'h0001_86A0);
    cycles(10);
    exp_wr("ld_stop", 3'd1, 16'h0008);
    exp_wr("ld_pl",   3'd2, 16'h86A0);
    exp_wr("ld_ph",   3'd3, 16'h0001);
    exp_wr("ld_ct",   3'd1, 16'h0007);

    // Period below minimum is clamped to 2
    load(32'h0000_0000);
    cycles(10);
    exp_wr("clamp_stop", 3'd1, 16'h0008);
    exp_wr("clamp_pl",   3'd2, 16'h0002);
    exp_wr("clamp_ph",   3'd3, 16'h0000);
    exp_wr("clamp_ct",   3'd1, 16'h0007);

    // irq and load in the same RUN cycle: ack first, then reprogram
    t0 = n_ticks;
    bus.timer_irq = 1'b1;
    load(32'h0012_3456);
    wait_wr(3'd0, found);
    bus.timer_irq = 1'b0;
    check("both_seen", {31'b0, found}, 32'd1);
    cycles(10);
    exp_wr("both_ack",  3'd0, 16'h0000);
    exp_wr("both_stop", 3'd1, 16'h0008);
    exp_wr("both_pl",   3'd2, 16'h3456);
    exp_wr("both_ph",   3'd3, 16'h0012);
    exp_wr("both_ct",   3'd1, 16'h0007);
    check("both_ticks", n_ticks - t0, 32'd1);
    check("both_tc",    tick_count,   2 * TC_INC);

    // Disable during WR_PH
    load(32'hABCD_1234);
    wait_wr(3'd3, found);
    cfg_enable = 1'b0;
    check("dis_seen", {31'b0, found}, 32'd1);
    cycles(10);
    exp_wr("dis_stop", 3'd1, 16'h0008);
    exp_wr("dis_pl",   3'd2, 16'h1234);
    exp_wr("dis_ph",   3'd3, 16'hABCD);
    exp_wr("dis_ct",   3'd1, 16'h0007);
    exp_wr("dis_stp2", 3'd1, 16'h0008);
    cycles(5);
    check("dis_nowr", wq.size(), 32'd0);
    @(negedge clk);
    check("dis_busy", {31'b0, busy}, 32'd0);

    // Reset during WR_PH abandons the sequence
    cfg_enable = 1'b1;
    wait_wr(3'd3, found);
    check("mid_seen", {31'b0, found}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_cs",    {31'b0, bus.avm_chipselect}, 32'd0);
    check("mid_wn",    {31'b0, bus.avm_write_n},    32'd1);
    check("mid_addr",  {29'b0, bus.avm_address},    32'd0);
    check("mid_wdata", {16'b0, bus.avm_writedata},  32'd0);
    check("mid_busy",  {31'b0, busy},               32'd0);
    exp_wr("mid_pl", 3'd2, 16'h1234);
    exp_wr("mid_ph", 3'd3, 16'hABCD);
    check("mid_nowr", wq.size(), 32'd0);
    cycles(2);
    reset_n = 1'b1;
    cycles(6);
    exp_wr("rel_pl", 3'd2, 16'hF07F);
    exp_wr("rel_ph", 3'd3, 16'h02FA);
    exp_wr("rel_ct", 3'd1, 16'h0007);
    check("rel_tc",   tick_count, 32'd0);
    check("rel_nowr", wq.size(),  32'd0);

    check("protocol", n_viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
